// File: rtl/adder_subtractor_multiprecision.sv
// Sequential multi-precision adder/subtractor: one CHUNK_WIDTH slice per clock, LS slice first.
// Optional saturation on signed overflow: define ADDER_SUBTRACTOR_MULTIPRECISION_SATURATE_EN.
module adder_subtractor_multiprecision #(
  parameter int TOTAL_WIDTH = 64,
  parameter int CHUNK_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   add_sub,
  input  logic                   carry_in,
  input  logic [TOTAL_WIDTH-1:0] A,
  input  logic [TOTAL_WIDTH-1:0] B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] sum,
  output logic                   carry_out,
  output logic                   overflow
);

  localparam int CHUNK_COUNT = TOTAL_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNK_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [CNT_W-1:0]         cnt_r;
  logic                     carry_r;
  logic [TOTAL_WIDTH-1:0]   a_r;
  logic [TOTAL_WIDTH-1:0]   b_r;
  logic [TOTAL_WIDTH-1:0]   sum_r;
  logic                     carry_out_r;
  logic                     overflow_r;
  logic                     in_ready_s;
  logic                     out_valid_s;
  logic                     accept_s;
  logic                     last_s;
  logic [CHUNK_WIDTH:0]     slice_full_s;
  logic [CHUNK_WIDTH-1:0]   slice_sum_s;
  logic                     slice_carry_s;
  logic                     msb_carry_in_s;
  logic                     slice_ovf_s;
  logic [TOTAL_WIDTH-1:0]   sum_shift_s;
  logic [TOTAL_WIDTH-1:0]   sum_final_s;

  // Operands shift right each CALC cycle, so the active slice is always the low CHUNK_WIDTH bits.
  assign slice_full_s   = {1'b0, a_r[CHUNK_WIDTH-1:0]} + {1'b0, b_r[CHUNK_WIDTH-1:0]}
                        + {{CHUNK_WIDTH{1'b0}}, carry_r};
  assign slice_sum_s    = slice_full_s[CHUNK_WIDTH-1:0];
  assign slice_carry_s  = slice_full_s[CHUNK_WIDTH];
  assign msb_carry_in_s = a_r[CHUNK_WIDTH-1] ^ b_r[CHUNK_WIDTH-1] ^ slice_sum_s[CHUNK_WIDTH-1];
  assign slice_ovf_s    = msb_carry_in_s ^ slice_carry_s;
  assign last_s         = (cnt_r == LAST_CNT);
  assign accept_s       = in_valid & (state_r == IDLE);

  // Result slices enter at the top and shift down; after CHUNK_COUNT cycles they are aligned.
  generate
    if (CHUNK_COUNT == 1) begin : g_single
      assign sum_shift_s = slice_sum_s;
    end else begin : g_multi
      assign sum_shift_s = {slice_sum_s, sum_r[TOTAL_WIDTH-1:CHUNK_WIDTH]};
    end
  endgenerate

`ifdef ADDER_SUBTRACTOR_MULTIPRECISION_SATURATE_EN
  localparam logic [TOTAL_WIDTH-1:0] SAT_MAX = {1'b0, {(TOTAL_WIDTH-1){1'b1}}};
  localparam logic [TOTAL_WIDTH-1:0] SAT_MIN = {1'b1, {(TOTAL_WIDTH-1){1'b0}}};

  // Clamp toward the sign of A when the final slice overflows.
  always_comb begin
    sum_final_s = sum_shift_s;
    if (slice_ovf_s) begin
      sum_final_s = a_r[CHUNK_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_final_s = sum_shift_s;
    end
  end
`else
  // Wrapped modulo result.
  always_comb begin
    sum_final_s = sum_shift_s;
  end
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next_s = state_r;
    in_ready_s   = 1'b0;
    out_valid_s  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        out_valid_s = 1'b1;
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Operand capture, per-slice arithmetic and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // Subtraction runs as A + ~B + ~borrow_in.
            a_r     <= A;
            b_r     <= add_sub ? ~B : B;
            carry_r <= add_sub ? ~carry_in : carry_in;
            cnt_r   <= '0;
          end
        end
        CALC: begin
          a_r     <= a_r >> CHUNK_WIDTH;
          b_r     <= b_r >> CHUNK_WIDTH;
          carry_r <= slice_carry_s;
          if (last_s) begin
            sum_r       <= sum_final_s;
            carry_out_r <= slice_carry_s;
            overflow_r  <= slice_ovf_s;
          end else begin
            sum_r <= sum_shift_s;
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_adder_subtractor_multiprecision.sv
// Directed/random bench for adder_subtractor_multiprecision at 16-bit width, 4-bit slices.
module tb_adder_subtractor_multiprecision;

  localparam int TW = 16;
  localparam int CW = 4;
  localparam int CC = TW / CW;

  typedef struct packed {
    logic [TW-1:0] sum;
    logic          cout;
    logic          ovf;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          add_sub = 1'b0;
  logic          carry_in = 1'b0;
  logic          out_ready = 1'b0;
  logic [TW-1:0] a = '0;
  logic [TW-1:0] b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [TW-1:0] sum;
  logic          carry_out;
  logic          overflow;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

`ifdef ADDER_SUBTRACTOR_MULTIPRECISION_SATURATE_EN
  localparam logic [TW-1:0] OVF_ADD_SUM = 16'h7FFF;
  localparam logic [TW-1:0] OVF_SUB_SUM = 16'h8000;
`else
  localparam logic [TW-1:0] OVF_ADD_SUM = 16'h8000;
  localparam logic [TW-1:0] OVF_SUB_SUM = 16'h7FFF;
`endif

  adder_subtractor_multiprecision #(.TOTAL_WIDTH(TW), .CHUNK_WIDTH(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_sub   (add_sub),
    .carry_in  (carry_in),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [TW-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  // Full-width reference: sub is A + ~B + ~borrow.
  function automatic exp_t model(input logic [TW-1:0] ma, input logic [TW-1:0] mb,
                                 input logic sub, input logic cin);
    logic [TW-1:0] be;
    logic          ce;
    logic [TW:0]   full;
    exp_t          e;
    be     = sub ? ~mb : mb;
    ce     = sub ? ~cin : cin;
    full   = {1'b0, ma} + {1'b0, be} + {{TW{1'b0}}, ce};
    e.sum  = full[TW-1:0];
    e.cout = full[TW];
    e.ovf  = (ma[TW-1] == be[TW-1]) && (full[TW-1] != ma[TW-1]);
`ifdef ADDER_SUBTRACTOR_MULTIPRECISION_SATURATE_EN
    if (e.ovf) e.sum = ma[TW-1] ? 16'h8000 : 16'h7FFF;
`endif
    return e;
  endfunction

  // Called at posedge+1 with the DUT idle; optionally holds DONE with out_ready low.
  task automatic run_op(input logic [TW-1:0] ta, input logic [TW-1:0] tb_v, input logic sub,
                        input logic cin, input exp_t e, input int hold);
    exp_t got;
    int   lat;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; add_sub = sub; carry_in = cin; in_valid = 1'b1;
    @(posedge clock); #1;
    exp_q.push_back(e);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    add_sub = 1'($urandom); carry_in = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(CC));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    got = exp_q.pop_front();
    check("sum", 32'(sum), 32'(got.sum));
    check("carry_out", 32'(carry_out), 32'(got.cout));
    check("overflow", 32'(overflow), 32'(got.ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = 16'($urandom);
      @(posedge clock); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(got.sum));
      check("hold_cout", 32'(carry_out), 32'(got.cout));
      check("hold_ovf", 32'(overflow), 32'(got.ovf));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic          rs;
    logic          rc;

    repeat (3) @(posedge clock);
    #1;
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0), 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(OVF_ADD_SUM, 1'b0, 1'b1), 0);
    run_op(16'h0000, 16'h0001, 1'b1, 1'b0, mk(16'hFFFF, 1'b0, 1'b0), 0);
    run_op(16'h0005, 16'h0003, 1'b1, 1'b1, mk(16'h0001, 1'b1, 1'b0), 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, mk(OVF_SUB_SUM, 1'b1, 1'b1), 10);
    run_op(16'hA5C3, 16'h1F0E, 1'b0, 1'b1, mk(16'hC4D2, 1'b0, 1'b0), 0);

    // Abort an operation two cycles into CALC.
    a = 16'h5555; b = 16'h7777; add_sub = 1'b0; carry_in = 1'b1; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check("abort_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0), 0);

    for (int n = 0; n < 6; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rs, rc, model(ra, rb, rs, rc), n % 2);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_subtractor_multiprecision.md
Name: adder_subtractor_multiprecision

Overview:
- Sequential multi-precision adder/subtractor for operands wider than a single fast carry chain.
- Splits TOTAL_WIDTH operands into CHUNK_WIDTH slices and processes one slice per clock, least-significant slice first.
- Carries between slices through a carry register.
- Valid/ready handshakes on input and output; used where wide arithmetic (e.g. 64/128-bit counters, accumulators) must meet timing with short carry chains.

Parameters:
- TOTAL_WIDTH, 64, operand/result width in bits; must be an integer multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 16, slice width processed per cycle; 1 <= CHUNK_WIDTH <= TOTAL_WIDTH.
- CHUNK_COUNT (localparam), TOTAL_WIDTH/CHUNK_WIDTH, number of CALC cycles per operation.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/command valid.
- in_ready  output  1  block can accept a command; high only in IDLE.
- add_sub  input  1  0 = A+B+carry_in, 1 = A-B-carry_in (carry_in acts as borrow).
- carry_in  input  1  carry (add) or borrow (sub) into bit 0.
- A  input  TOTAL_WIDTH  first operand.
- B  input  TOTAL_WIDTH  second operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  TOTAL_WIDTH  result, held stable while out_valid.
- carry_out  output  1  raw carry out of MSB; for subtraction 1 means no borrow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset: async on reset rising or high.
  - State goes to IDLE; chunk counter, carry register and operand registers go to 0.
  - Outputs: sum = 0, carry_out = 0, overflow = 0, out_valid = 0, in_ready = 1.
- States: IDLE, CALC, DONE.
- IDLE: in_ready = 1.
  - On in_valid & in_ready, latch A and B_eff, where B_eff = B for add and ~B for sub.
  - Set carry register = carry_in for add, ~carry_in for sub. Sub is therefore computed as A + ~B + ~borrow_in.
  - Clear chunk counter; go to CALC.
- CALC: in_ready = 0, out_valid = 0. Each cycle at slice i = counter:
  - {c, s} = A[i] + B_eff[i] + carry register, at CHUNK_WIDTH+1 bits.
  - Write s into sum slice i; carry register <= c; counter increments.
  - On the last slice (counter = CHUNK_COUNT-1):
    - carry_out <= c.
    - overflow <= carry into MSB XOR c. The carry into the MSB is computed inside the slice as A_msb ^ B_eff_msb ^ s_msb.
    - Go to DONE.
- DONE: out_valid = 1; sum, carry_out and overflow are held.
  - On out_ready, go to IDLE. A new command is accepted no earlier than the following cycle.
- Latency: out_valid rises exactly CHUNK_COUNT clock edges after the accepting edge.
  - Throughput: one operation per CHUNK_COUNT+2 cycles at best.
- Input side during CALC/DONE: in_valid and operand changes are ignored (in_ready = 0).
- Backpressure: out_ready low in DONE holds all outputs indefinitely.
- CHUNK_COUNT = 1: a single CALC cycle, result identical to a combinational TOTAL_WIDTH add.
- Counter width: clog2(CHUNK_COUNT), minimum 1 bit. The counter never wraps past CHUNK_COUNT-1.
- Reset mid-CALC or mid-DONE: the partial result is discarded, with no out_valid pulse; reset values apply immediately.
- sum register bits not yet written in CALC are undefined to the consumer; out_valid is the sole qualifier.

Optional Feature:
- Macro: ADDER_SUBTRACTOR_MULTIPRECISION_SATURATE_EN.
- Defined: on the last slice, if signed overflow occurs, sum is replaced with a saturated value and overflow is still reported as 1.
  - A MSB = 0 gives the maximum positive value, 0111...1.
  - A MSB = 1 gives the minimum negative value, 1000...0.
  - carry_out is unchanged (raw).
- Undefined: sum is the wrapped modulo-2^TOTAL_WIDTH result. No saturation logic is present.

Test Plan (TOTAL_WIDTH = 16, CHUNK_WIDTH = 4):
- Add: 0x00FF + 0x0001, cin 0 -> sum 0x0100, carry_out 0, overflow 0; out_valid exactly 4 edges after accept.
- Signed overflow on add: 0x7FFF + 0x0001 -> sum 0x8000, overflow 1, carry_out 0. With SATURATE_EN: sum 0x7FFF, overflow 1.
- Subtract with borrow: 0x0000 - 0x0001, cin 0 -> sum 0xFFFF, carry_out 0, overflow 0. Then 0x0005 - 0x0003, cin 1 -> sum 0x0001, carry_out 1.
- Negative overflow on sub: 0x8000 - 0x0001 -> sum 0x7FFF, overflow 1, carry_out 1. With SATURATE_EN: sum 0x8000.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE while toggling in_valid/A -> sum, carry_out and overflow are stable and in_ready = 0. Release -> IDLE the next cycle and the next command is accepted correctly.
- Reset at CALC cycle 2 -> out_valid stays 0, in_ready = 1 immediately. A subsequent 0x1234 + 0x1111 gives 0x2345 with no residue from the aborted operation.
